// File: rtl/gat_layer_scheduler_if.sv
// Control/status bundle between the PS-facing layer scheduler and its environment.
// The slave modport is the scheduler's view; the master modport is the PS/engine side.
interface gat_layer_scheduler_if #(
    parameter int CYCLE_CNT_WIDTH = 32
);
    logic                       start;
    logic                       abort;
    logic                       h_data_bram_load_done;
    logic                       h_node_info_bram_load_done;
    logic                       wgt_bram_load_done;
    logic                       conv1_done;
    logic                       conv2_done;

    logic                       gat_layer;
    logic                       conv1_start;
    logic                       conv2_start;
    logic                       busy;
    logic                       done;
    logic                       irq;
    logic [CYCLE_CNT_WIDTH-1:0] layer1_cycles;
    logic [CYCLE_CNT_WIDTH-1:0] layer2_cycles;
    logic [2:0]                 state;

    modport master (
        output start, abort,
        output h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done,
        output conv1_done, conv2_done,
        input  gat_layer, conv1_start, conv2_start, busy, done, irq,
        input  layer1_cycles, layer2_cycles, state
    );

    modport slave (
        input  start, abort,
        input  h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done,
        input  conv1_done, conv2_done,
        output gat_layer, conv1_start, conv2_start, busy, done, irq,
        output layer1_cycles, layer2_cycles, state
    );
endinterface

// File: rtl/gat_layer_scheduler.sv
// Two-layer GAT sequencer: waits for BRAM loads, runs conv1, drains, flips the
// shared-memory select, runs conv2, then flags completion with done/irq.
module gat_layer_scheduler #(
    parameter int CYCLE_CNT_WIDTH = 32,
    parameter int DRAIN_CYCLES    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gat_layer_scheduler_if.slave  bus
);

    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int DRAIN_W   = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOAD = 3'd1,
        S_CONV1     = 3'd2,
        S_DRAIN     = 3'd3,
        S_CONV2     = 3'd4,
        S_FINISH    = 3'd5
    } state_e;

    state_e                     state_q, state_d;
    logic                       gat_q, gat_d;
    logic                       c1s_q, c1s_d;
    logic                       c2s_q, c2s_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       irq_q, irq_d;
    logic [CYCLE_CNT_WIDTH-1:0] l1_q, l1_d;
    logic [CYCLE_CNT_WIDTH-1:0] l2_q, l2_d;
    logic [DRAIN_W-1:0]         drain_q, drain_d;
    logic                       loads_ok;

    // Profiling counters stick at all-ones rather than wrapping.
    function automatic logic [CYCLE_CNT_WIDTH-1:0] sat_inc(
        input logic [CYCLE_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + CYCLE_CNT_WIDTH'(1);
    endfunction

    assign loads_ok = bus.h_data_bram_load_done &
                      bus.h_node_info_bram_load_done &
                      bus.wgt_bram_load_done;

    always_comb begin
        state_d = state_q;
        gat_d   = gat_q;
        c1s_d   = 1'b0;
        c2s_d   = 1'b0;
        done_d  = done_q;
        irq_d   = 1'b0;
        l1_d    = l1_q;
        l2_d    = l2_q;
        drain_d = drain_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_WAIT_LOAD;
                    done_d  = 1'b0;
                    gat_d   = 1'b0;
                    l1_d    = '0;
                    l2_d    = '0;
                end
            end
            S_WAIT_LOAD: begin
                if (loads_ok) begin
                    state_d = S_CONV1;
                    c1s_d   = 1'b1;
                end
            end
            S_CONV1: begin
                l1_d = sat_inc(l1_q);
                if (bus.conv1_done) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                // Hold the mux on conv1 until in-flight conv1 writes have retired.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_CONV2;
                    gat_d   = 1'b1;
                    c2s_d   = 1'b1;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            S_CONV2: begin
                l2_d = sat_inc(l2_q);
                if (bus.conv2_done) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                gat_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        // Abort overrides everything except the counters, which keep what they saw.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            gat_d   = 1'b0;
            done_d  = 1'b0;
            irq_d   = 1'b0;
            c1s_d   = 1'b0;
            c2s_d   = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gat_q   <= 1'b0;
            c1s_q   <= 1'b0;
            c2s_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
            l1_q    <= '0;
            l2_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            gat_q   <= gat_d;
            c1s_q   <= c1s_d;
            c2s_q   <= c2s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            irq_q   <= irq_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            drain_q <= drain_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.gat_layer     = gat_q;
    assign bus.conv1_start   = c1s_q;
    assign bus.conv2_start   = c2s_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.irq           = irq_q;
    assign bus.layer1_cycles = l1_q;
    assign bus.layer2_cycles = l2_q;

endmodule

// File: tb/tb_gat_layer_scheduler.sv
// Directed bench for gat_layer_scheduler: a default instance (32-bit counters,
// four drain cycles) and a narrow instance (4-bit counters, drain of zero).
module tb_gat_layer_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   c1n = 0;
    int   c2n = 0;

    always #5 clk = ~clk;

    gat_layer_scheduler_if #(.CYCLE_CNT_WIDTH(32)) bus_a ();
    gat_layer_scheduler_if #(.CYCLE_CNT_WIDTH(4))  bus_b ();

    gat_layer_scheduler #(.CYCLE_CNT_WIDTH(32), .DRAIN_CYCLES(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    gat_layer_scheduler #(.CYCLE_CNT_WIDTH(4), .DRAIN_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_a.conv1_start === 1'b1) c1n++;
        if (bus_a.conv2_start === 1'b1) c2n++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    function automatic logic [8:0] ctrl_a();
        return {bus_a.state, bus_a.busy, bus_a.done, bus_a.irq,
                bus_a.gat_layer, bus_a.conv1_start, bus_a.conv2_start};
    endfunction

    function automatic logic [8:0] ctrl_b();
        return {bus_b.state, bus_b.busy, bus_b.done, bus_b.irq,
                bus_b.gat_layer, bus_b.conv1_start, bus_b.conv2_start};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.start = 0; bus_a.abort = 0; bus_a.conv1_done = 0; bus_a.conv2_done = 0;
        bus_a.h_data_bram_load_done = 0; bus_a.h_node_info_bram_load_done = 0;
        bus_a.wgt_bram_load_done = 0;
        bus_b.start = 0; bus_b.abort = 0; bus_b.conv1_done = 0; bus_b.conv2_done = 0;
        bus_b.h_data_bram_load_done = 0; bus_b.h_node_info_bram_load_done = 0;
        bus_b.wgt_bram_load_done = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl_a", 32'(ctrl_a()), 32'd0);
        check("reset_l1_a", bus_a.layer1_cycles, 32'd0);
        check("reset_l2_a", bus_a.layer2_cycles, 32'd0);
        check("reset_ctrl_b", 32'(ctrl_b()), 32'd0);
        rst_n = 1'b1;
        step();

        // Nominal run with stray inputs
        bus_a.h_data_bram_load_done = 1;
        bus_a.h_node_info_bram_load_done = 1;
        bus_a.wgt_bram_load_done = 1;
        bus_a.start = 1; cyc = 0; c1n = 0; c2n = 0;
        step(); bus_a.start = 0;
        check("t1_wait_state", bus_a.state, 32'd1);
        check("t1_wait_busy", bus_a.busy, 32'd1);
        step();
        check("t1_conv1_state", bus_a.state, 32'd2);
        check("t1_conv1_start", bus_a.conv1_start, 32'd1);
        step();
        check("t1_conv1_start_drop", bus_a.conv1_start, 32'd0);
        go_to(5); bus_a.conv2_done = 1;
        step(); bus_a.conv2_done = 0;
        check("t1_stray_c2done", bus_a.state, 32'd2);
        go_to(11); bus_a.conv1_done = 1;
        step(); bus_a.conv1_done = 0;
        check("t1_drain_state", bus_a.state, 32'd3);
        check("t1_layer1", bus_a.layer1_cycles, 32'd10);
        check("t1_drain_gat", bus_a.gat_layer, 32'd0);
        go_to(15);
        check("t1_drain_last", bus_a.state, 32'd3);
        step();
        check("t1_conv2_state", bus_a.state, 32'd4);
        check("t1_conv2_gat", bus_a.gat_layer, 32'd1);
        check("t1_conv2_start", bus_a.conv2_start, 32'd1);
        step();
        check("t1_conv2_start_drop", bus_a.conv2_start, 32'd0);
        go_to(20); bus_a.start = 1; bus_a.conv1_done = 1;
        step(); bus_a.start = 0; bus_a.conv1_done = 0;
        check("t1_stray_start", bus_a.state, 32'd4);
        check("t1_stray_no_c1s", bus_a.conv1_start, 32'd0);
        go_to(25); bus_a.conv2_done = 1;
        step(); bus_a.conv2_done = 0;
        check("t1_finish_state", bus_a.state, 32'd5);
        check("t1_irq", bus_a.irq, 32'd1);
        check("t1_done", bus_a.done, 32'd1);
        check("t1_layer2", bus_a.layer2_cycles, 32'd10);
        step();
        check("t1_idle_ctrl", 32'(ctrl_a()), 32'b000_0_1_0_1_0_0);
        check("t1_layer1_hold", bus_a.layer1_cycles, 32'd10);
        check("t1_c1_launches", c1n, 32'd1);
        check("t1_c2_launches", c2n, 32'd1);

        // Load gating, first-cycle conv1_done, abort vs conv2_done
        step();
        bus_a.wgt_bram_load_done = 0;
        bus_a.start = 1; cyc = 0;
        step(); bus_a.start = 0;
        check("t2_wait_state", bus_a.state, 32'd1);
        check("t2_done_cleared", bus_a.done, 32'd0);
        check("t2_gat_cleared", bus_a.gat_layer, 32'd0);
        check("t2_l1_cleared", bus_a.layer1_cycles, 32'd0);
        check("t2_l2_cleared", bus_a.layer2_cycles, 32'd0);
        repeat (19) begin
            step();
            check("t2_wait_hold", bus_a.state, 32'd1);
        end
        bus_a.wgt_bram_load_done = 1;
        step();
        check("t2_conv1_state", bus_a.state, 32'd2);
        check("t2_conv1_start", bus_a.conv1_start, 32'd1);
        bus_a.conv1_done = 1;
        bus_a.h_data_bram_load_done = 0;
        step(); bus_a.conv1_done = 0;
        check("t3_first_cycle_done", bus_a.state, 32'd3);
        check("t3_layer1_one", bus_a.layer1_cycles, 32'd1);
        go_to(26);
        check("t3_conv2_state", bus_a.state, 32'd4);
        check("t3_conv2_start", bus_a.conv2_start, 32'd1);
        step(); bus_a.start = 1;
        step(); bus_a.start = 0;
        check("t3_stray_start", bus_a.state, 32'd4);
        go_to(30); bus_a.abort = 1; bus_a.conv2_done = 1;
        step(); bus_a.abort = 0; bus_a.conv2_done = 0;
        check("t3_abort_ctrl", 32'(ctrl_a()), 32'd0);
        check("t3_abort_layer2", bus_a.layer2_cycles, 32'd5);
        step();
        check("t3_no_late_irq", bus_a.irq, 32'd0);
        bus_a.abort = 1;
        step(); bus_a.abort = 0;
        check("t3_idle_abort_state", bus_a.state, 32'd0);
        check("t3_idle_abort_l2", bus_a.layer2_cycles, 32'd5);
        bus_a.h_data_bram_load_done = 1;

        // Narrow instance: saturation and zero drain
        bus_b.h_data_bram_load_done = 1;
        bus_b.h_node_info_bram_load_done = 1;
        bus_b.wgt_bram_load_done = 1;
        bus_b.start = 1; cyc = 0;
        step(); bus_b.start = 0;
        go_to(2);
        check("t4_conv1_state", bus_b.state, 32'd2);
        go_to(41); bus_b.conv1_done = 1;
        step(); bus_b.conv1_done = 0;
        check("t4_drain_state", bus_b.state, 32'd3);
        check("t4_layer1_sat", bus_b.layer1_cycles, 32'd15);
        step();
        check("t4_conv2_state", bus_b.state, 32'd4);
        check("t4_conv2_start", bus_b.conv2_start, 32'd1);
        check("t4_conv2_gat", bus_b.gat_layer, 32'd1);
        bus_b.conv2_done = 1;
        step(); bus_b.conv2_done = 0;
        check("t4_finish_irq", bus_b.irq, 32'd1);
        check("t4_layer2", bus_b.layer2_cycles, 32'd1);
        step();
        check("t4_idle_done", 32'(ctrl_b()), 32'b000_0_1_0_1_0_0);

        // Asynchronous reset mid-DRAIN, then a fresh run
        step();
        bus_a.start = 1; cyc = 0;
        step(); bus_a.start = 0;
        go_to(3); bus_a.conv1_done = 1;
        step(); bus_a.conv1_done = 0;
        check("t5_drain_state", bus_a.state, 32'd3);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_ctrl_a", 32'(ctrl_a()), 32'd0);
        check("t5_async_l1_a", bus_a.layer1_cycles, 32'd0);
        check("t5_async_ctrl_b", 32'(ctrl_b()), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        bus_a.start = 1; cyc = 0;
        step(); bus_a.start = 0;
        go_to(4); bus_a.conv1_done = 1;
        step(); bus_a.conv1_done = 0;
        check("t5_drain_again", bus_a.state, 32'd3);
        check("t5_layer1", bus_a.layer1_cycles, 32'd3);
        go_to(9);
        check("t5_conv2_state", bus_a.state, 32'd4);
        check("t5_conv2_gat", bus_a.gat_layer, 32'd1);
        go_to(10); bus_a.conv2_done = 1;
        step(); bus_a.conv2_done = 0;
        check("t5_finish_irq", bus_a.irq, 32'd1);
        check("t5_layer2", bus_a.layer2_cycles, 32'd2);
        step();
        check("t5_idle_ctrl", 32'(ctrl_a()), 32'b000_0_1_0_1_0_0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gat_layer_scheduler.md
Name: gat_layer_scheduler

Overview:
Top-level sequencer for the two-layer GAT datapath. It waits for the PS to finish loading the H-data, node-info and weight BRAMs, then launches conv1. After conv1 completes and a drain interval passes, it flips the shared-memory select `gat_layer` and launches conv2. It reports completion to the PS through a sticky done flag and a one-cycle irq, and keeps per-layer cycle counts for profiling. It drives the `gat_layer` select consumed by memory_controller.

Parameters:
- CYCLE_CNT_WIDTH, 32, width of the per-layer cycle counters; counters saturate at all-ones.
- DRAIN_CYCLES, 4, cycles spent in DRAIN between conv1_done and the conv2 launch, so in-flight conv1 BRAM writes retire before the mux switches. A value of 0 is treated as 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, active-low, asynchronous assert.
- start  in  1  PS run request; level or pulse, sampled only in IDLE.
- abort  in  1  PS abort; highest priority.
- h_data_bram_load_done  in  1  PS level: H data loaded.
- h_node_info_bram_load_done  in  1  PS level: node info loaded.
- wgt_bram_load_done  in  1  PS level: weights loaded.
- conv1_done  in  1  one-cycle pulse from the conv1 engine.
- conv2_done  in  1  one-cycle pulse from the conv2 engine.
- gat_layer  out  1  memory mux select: 0 = conv1, 1 = conv2.
- conv1_start  out  1  one-cycle launch pulse.
- conv2_start  out  1  one-cycle launch pulse.
- busy  out  1  high in any state other than IDLE.
- done  out  1  sticky completion flag.
- irq  out  1  one-cycle completion pulse.
- layer1_cycles  out  CYCLE_CNT_WIDTH  cycles spent in CONV1.
- layer2_cycles  out  CYCLE_CNT_WIDTH  cycles spent in CONV2.
- state  out  3  encoded FSM state, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: every output is 0, and state = IDLE (0).
- All outputs are registered.
- State encoding: IDLE=0, WAIT_LOAD=1, CONV1=2, DRAIN=3, CONV2=4, FINISH=5. Codes 6 and 7 are illegal and recover to IDLE on the next cycle.
- IDLE:
  - On start, go to WAIT_LOAD.
  - On that transition: done←0, gat_layer←0, layer1_cycles←0, layer2_cycles←0.
- WAIT_LOAD: once all three load_done inputs are high in the same cycle, go to CONV1.
- CONV1:
  - conv1_start is high only in the first CONV1 cycle.
  - layer1_cycles increments every CONV1 cycle, including the first, and saturates at all-ones.
  - On conv1_done, go to DRAIN. A conv1_done in the first CONV1 cycle is accepted.
- DRAIN:
  - gat_layer stays 0.
  - Stay max(DRAIN_CYCLES,1) cycles, then go to CONV2.
- CONV2:
  - gat_layer←1 on entry.
  - conv2_start is high in the first CONV2 cycle only.
  - layer2_cycles counts and saturates with the same rules as layer1_cycles.
  - On conv2_done, go to FINISH.
- FINISH:
  - Lasts exactly one cycle: irq=1, done←1, then go to IDLE.
  - done and gat_layer=1 hold until the next accepted start.
- Ignored inputs:
  - start outside IDLE.
  - conv1_done outside CONV1; conv2_done outside CONV2.
  - load_done falling after CONV1 is entered.
- Abort:
  - In any non-IDLE state, go to IDLE on the next cycle with gat_layer←0 and done←0. No irq, no start pulses.
  - Counters hold their values.
  - Abort beats a same-cycle conv*_done.
  - Abort in IDLE is a no-op.
- Latency: start at cycle t with loads already high gives WAIT_LOAD at t+1 and CONV1 plus conv1_start at t+2.
- Reset mid-run: all outputs return to reset values immediately, regardless of clk.

Test Plan:
- DRAIN_CYCLES=4; loads high; start at cycle 0; conv1_done at 11; conv2_done at 25.
  - Expect conv1_start at 2 and DRAIN over cycles 12–15.
  - Expect gat_layer=1 and conv2_start at 16.
  - Expect irq at 26 and IDLE at 27.
  - Expect layer1_cycles=10, layer2_cycles=10, done=1 held.
- Start with wgt_bram_load_done low; raise it at cycle 20 → state stays 1 until 20, conv1_start at 21.
- Abort asserted together with conv2_done at the 5th CONV2 cycle → IDLE next cycle; gat_layer=0, irq never fires, done=0, layer2_cycles=5.
- CYCLE_CNT_WIDTH=4 with conv1_done after 40 CONV1 cycles → layer1_cycles=15.
- Stray conv2_done during CONV1 and start pulses during CONV2 → no state change; conv1/conv2 each launch exactly once.
- rst_n low mid-DRAIN → all outputs 0 asynchronously; after release, a new start completes normally.
